// File: rtl/gate_truth_checker.sv
// Clocked stimulus-and-check stage for a 2-input gate: walks {in2,in1} through 00..11,
// holds each vector SETTLE_CYCLES cycles, samples dut_out and records mismatches.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 7,
    parameter logic [3:0]  EXPECT        = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx,
    output logic [2:0] mismatch_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("gate_truth_checker: SETTLE_CYCLES must be in 1..255");
        end
    endgenerate

    logic [1:0] state;
    logic [7:0] settle_cnt;
    logic       miss;
    logic [3:0] fail_next;

    // Case inequality so an X or Z from the gate is reported as a mismatch.
    assign miss = (dut_out !== EXPECT[vec_idx]);

    always_comb begin
        fail_next = fail_mask;
        if (miss) begin
            fail_next[vec_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= 8'd0;
            vec_idx      <= 2'd0;
            in1          <= 1'b0;
            in2          <= 1'b0;
            fail_mask    <= 4'd0;
            mismatch_cnt <= 3'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= SETTLE;
                        settle_cnt   <= RELOAD;
                        vec_idx      <= 2'd0;
                        in1          <= 1'b0;
                        in2          <= 1'b0;
                        fail_mask    <= 4'd0;
                        mismatch_cnt <= 3'd0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (miss) begin
                        fail_mask    <= fail_next;
                        mismatch_cnt <= mismatch_cnt + 3'd1;
                    end
                    // pass is taken from the mask including this final sample.
                    if (vec_idx == 2'd3) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_next == 4'd0);
                    end else begin
                        state        <= SETTLE;
                        settle_cnt   <= RELOAD;
                        vec_idx      <= vec_idx + 2'd1;
                        {in2, in1}   <= vec_idx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: a modelled gate (OR, AND or X) feeds two checker
// instances (SETTLE_CYCLES 7 and 1); expected results are queued at start and popped at DONE.
module tb_gate_truth_checker;

    localparam logic [3:0] EXP_OR = 4'b1110;
    localparam int S_A = 7;
    localparam int S_B = 1;

    typedef struct {
        logic [3:0] fm;
        logic [2:0] mc;
        logic       pass;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic out_a, out_b;
    logic in1_a, in2_a, busy_a, done_a, pass_a;
    logic in1_b, in2_b, busy_b, done_b, pass_b;
    logic [3:0] fm_a, fm_b;
    logic [1:0] vi_a, vi_b;
    logic [2:0] mc_a, mc_b;

    logic o_in1, o_in2, o_busy, o_done, o_pass;
    logic [3:0] o_fm;
    logic [1:0] o_vi;
    logic [2:0] o_mc;

    int mode = 0;   // 0: OR gate, 1: AND gate, 2: output stuck at X
    int sel = 0;    // 0: instance with S=7, 1: instance with S=1
    int checks = 0;
    int errors = 0;

    gate_truth_checker #(.SETTLE_CYCLES(S_A), .EXPECT(4'b1110)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_out(out_a),
        .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_mask(fm_a), .vec_idx(vi_a), .mismatch_cnt(mc_a)
    );

    gate_truth_checker #(.SETTLE_CYCLES(S_B), .EXPECT(4'b1110)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_out(out_b),
        .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_mask(fm_b), .vec_idx(vi_b), .mismatch_cnt(mc_b)
    );

    always #5 clk = ~clk;

    function automatic logic gate_fn(input int m, input logic [1:0] v);
        case (m)
            0:       return v[0] | v[1];
            1:       return v[0] & v[1];
            default: return 1'bx;
        endcase
    endfunction

    always_comb out_a = gate_fn(mode, {in2_a, in1_a});
    always_comb out_b = gate_fn(mode, {in2_b, in1_b});

    always_comb begin
        if (sel == 1) begin
            o_in1 = in1_b; o_in2 = in2_b; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            o_fm = fm_b; o_vi = vi_b; o_mc = mc_b;
        end else begin
            o_in1 = in1_a; o_in2 = in2_a; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            o_fm = fm_a; o_vi = vi_a; o_mc = mc_a;
        end
    end

    task automatic drive_start(input logic v);
        if (sel == 1) start_b = v;
        else          start_a = v;
    endtask

    // One full run on the selected instance; poke pulses start in cycles 3 and 10 mid-run.
    task automatic run_vectors(input int s, input bit poke);
        exp_t e;
        exp_t got;
        logic g;
        int   k;
        e.fm = 4'd0;
        e.mc = 3'd0;
        for (int v = 0; v < 4; v++) begin
            g = gate_fn(mode, 2'(v));
            if (g !== EXP_OR[v]) begin
                e.fm[v] = 1'b1;
                e.mc    = e.mc + 3'd1;
            end
        end
        e.pass = (e.fm == 4'd0);
        sb.push_back(e);

        @(negedge clk);
        drive_start(1'b1);
        @(posedge clk); #1;
        for (int ed = 0; ed < 4 * (s + 1); ed++) begin
            drive_start(poke && (ed + 1 == 3 || ed + 1 == 10));
            k = ed / (s + 1);
            checks++;
            if ({o_in2, o_in1} !== 2'(k) || o_vi !== 2'(k)) begin
                errors++;
                $display("FAIL vector cycle %0d: in2in1=%b vec_idx=%0d required %0d",
                         ed + 1, {o_in2, o_in1}, o_vi, k);
            end
            checks++;
            if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL busy_done cycle %0d: busy=%b done=%b required busy=1 done=0",
                         ed + 1, o_busy, o_done);
            end
            if (ed <= s) begin
                checks++;
                if (o_fm !== 4'd0 || o_mc !== 3'd0) begin
                    errors++;
                    $display("FAIL cleared cycle %0d: fail_mask=%b mismatch_cnt=%0d required 0000/0",
                             ed + 1, o_fm, o_mc);
                end
            end
            @(posedge clk); #1;
        end
        drive_start(1'b0);

        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle %0d: done=%b busy=%b required done=1 busy=0",
                     4 * (s + 1) + 1, o_done, o_busy);
        end
        checks++;
        if (o_in1 !== 1'b1 || o_in2 !== 1'b1) begin
            errors++;
            $display("FAIL last_vector: in1=%b in2=%b required 1 1", o_in1, o_in2);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: size=0 required >=1");
        end else begin
            got = sb.pop_front();
            if (o_fm !== got.fm || o_mc !== got.mc || o_pass !== got.pass) begin
                errors++;
                $display("FAIL result: fail_mask=%b cnt=%0d pass=%b required %b/%0d/%b",
                         o_fm, o_mc, o_pass, got.fm, got.mc, got.pass);
            end
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (o_in1 !== 1'b0 || o_in2 !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_pass !== 1'b0 || o_fm !== 4'd0 || o_vi !== 2'd0 || o_mc !== 3'd0) begin
            errors++;
            $display("FAIL %s: in=%b%b busy=%b done=%b pass=%b fm=%b vi=%0d mc=%0d required all 0",
                     name, o_in2, o_in1, o_busy, o_done, o_pass, o_fm, o_vi, o_mc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sel = 0; #1; check_idle("reset_a");
        sel = 1; #1; check_idle("reset_b");
        sel = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_or_run();
        sel = 0; mode = 0;
        run_vectors(S_A, 1'b0);
        checks++;
        if (o_pass !== 1'b1 || o_fm !== 4'b0000 || o_mc !== 3'd0) begin
            errors++;
            $display("FAIL or_fixed: pass=%b fm=%b mc=%0d required 1/0000/0", o_pass, o_fm, o_mc);
        end
    endtask

    task automatic test_and_run();
        sel = 0; mode = 1;
        run_vectors(S_A, 1'b0);
        checks++;
        if (o_pass !== 1'b0 || o_fm !== 4'b0110 || o_mc !== 3'd2) begin
            errors++;
            $display("FAIL and_fixed: pass=%b fm=%b mc=%0d required 0/0110/2", o_pass, o_fm, o_mc);
        end
    endtask

    // Restart straight from the failing AND result; the run checks results are cleared.
    task automatic test_restart_from_done();
        sel = 0; mode = 0;
        run_vectors(S_A, 1'b0);
    endtask

    task automatic test_start_ignored();
        sel = 0; mode = 0;
        run_vectors(S_A, 1'b1);
    endtask

    task automatic test_x_output();
        sel = 0; mode = 2;
        run_vectors(S_A, 1'b0);
    endtask

    task automatic test_mid_reset();
        sel = 0; mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b1 || o_in1 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset cycle 12: busy=%b in1=%b required 1 1", o_busy, o_in1);
        end
        #2 rst = 1'b1;
        #1 check_idle("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("idle_after_reset");
        run_vectors(S_A, 1'b0);
        checks++;
        if (o_pass !== 1'b1) begin
            errors++;
            $display("FAIL pass_after_reset: pass=%b required 1", o_pass);
        end
    endtask

    task automatic test_short_settle();
        sel = 1; mode = 0;
        run_vectors(S_B, 1'b0);
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_or_run();
        test_and_run();
        test_restart_from_done();
        test_start_ignored();
        test_x_output();
        test_mid_reset();
        test_short_settle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: size=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Sequential stimulus-and-check stage for a 2-input combinational gate (default target: the team's OR gate).
- Drives the gate's two inputs through all four input vectors. Waits a settle interval per vector, samples the gate output, and compares it against a parameterised truth table.
- Sits directly upstream of the gate (drives in1/in2) and consumes its output. Replaces hand-written delay-and-display benches with a self-checking, clocked block.

Parameters:
- SETTLE_CYCLES, 7, clock cycles each vector is held before sampling; legal range 1..255; out-of-range values are an elaboration error.
- EXPECT, 4'b1110, expected gate output indexed by {in2,in1}; default is the OR truth table.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a check run; sampled only in IDLE or DONE
- dut_out  input  1  output of the gate under test
- in1  output  1  gate input 1 (registered)
- in2  output  1  gate input 2 (registered)
- busy  output  1  high while a run is in progress (SETTLE or SAMPLE)
- done  output  1  high in DONE state
- pass  output  1  valid while done=1; 1 when fail_mask==0
- fail_mask  output  4  bit k set if vector k ({in2,in1}=k) mismatched
- vec_idx  output  2  index of the vector currently applied
- mismatch_cnt  output  3  number of mismatching vectors, 0..4

Behaviour:
- Reset (async, rst=1): state=IDLE; in1=in2=0, vec_idx=0, fail_mask=0, mismatch_cnt=0, busy=0, done=0, pass=0; settle counter=0. Takes effect immediately, including mid-run; the partial run is discarded.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: outputs hold their reset values. start=1 at an edge -> SETTLE.
  - On that edge: vec_idx=0, {in2,in1}=2'b00, counter=SETTLE_CYCLES-1, fail_mask=0, mismatch_cnt=0.
- SETTLE: {in2,in1} holds vec_idx; counter decrements each cycle. When counter==0 at an edge -> SAMPLE. Each vector occupies exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE (one cycle): compare dut_out against EXPECT[vec_idx] using case equality; X or Z on dut_out counts as a mismatch. On mismatch: set fail_mask[vec_idx] and increment mismatch_cnt.
  - If vec_idx==3: -> DONE.
  - Otherwise: vec_idx+1, new {in2,in1}=vec_idx+1, counter reloaded to SETTLE_CYCLES-1, -> SETTLE.
- DONE: done=1, busy=0, pass=(fail_mask==0). in1/in2 keep the last vector (1,1). fail_mask and mismatch_cnt hold. start=1 at an edge restarts exactly as from IDLE and clears results on that edge.
- start is ignored while busy=1. A held-high start in DONE restarts on every completion.
- Timing: start edge = cycle 0. Vector k is applied from cycle 1+k*(S+1) and sampled in cycle (k+1)*(S+1), where S=SETTLE_CYCLES. DONE is entered at cycle 4*(S+1)+1; with S=7, done rises at cycle 33.
- vec_idx wraps only by restart, never by increment past 3. mismatch_cnt cannot overflow (max 4 fits 3 bits).
- All outputs are registered. No combinational path from dut_out or start to any output.

Test Plan:
- Correct OR gate, S=7: pulse start -> in1/in2 sequence 00,10,01,11 (in1,in2), each held 7 cycles; done=1 at cycle 33, pass=1, fail_mask=0000, mismatch_cnt=0.
- Gate replaced by AND, EXPECT default: run -> fail_mask=0110, mismatch_cnt=2, pass=0.
- dut_out tied to X: run -> fail_mask=1111, mismatch_cnt=4, pass=0.
- S=1: run -> done rises at cycle 9; each vector applied for exactly 1 cycle before its sample cycle.
- Assert rst at cycle 12 mid-run -> all outputs return to reset values immediately, state IDLE. Fresh start afterwards -> full correct run, pass=1.
- start pulsed at cycles 3 and 10 during a run -> ignored, timing unchanged. start in DONE -> fail_mask/mismatch_cnt cleared and vector 00 re-applied on the next edge.
